// File: rtl/stage_tl_if.sv
// Memory request/acknowledge port between the translation stage (master) and the data memory (slave).
interface stage_tl_if;
    logic        req;
    logic        we;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output we, output addr, output wdata, input ack, input rdata);
    modport slave  (input req, input we, input addr, input wdata, output ack, output rdata);
endinterface

// File: rtl/stage_tl.sv
// Translation/memory stage between EX and WB: dTLB lookup, memory access over a req/ack port,
// and the registered tl_* bundle consumed by WB.
module stage_tl #(
    parameter int unsigned DTLB_ENTRIES = 4,
    parameter logic [31:0] BUBBLE_PC    = 32'hFFFF_FFFF,
    parameter int unsigned THREAD_W     = 2,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned TLBW_W       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [THREAD_W-1:0] ex_thread,
    input  logic                ex_isvalid,
    input  logic                ex_itlb_miss,
    input  logic [REG_W-1:0]    ex_dst,
    input  logic [31:0]         ex_pc,
    input  logic [31:0]         ex_r2,
    input  logic [31:0]         ex_alu,
    input  logic                ex_isequal,
    input  logic [31:0]         ex_mul,
    input  logic                ex_flag_mul,
    input  logic                ex_flag_reg,
    input  logic                ex_flag_jump,
    input  logic                ex_flag_branch,
    input  logic                ex_flag_iret,
    input  logic [TLBW_W-1:0]   ex_flag_tlbwrite,
    input  logic                ex_flag_load,
    input  logic                ex_flag_store,
    input  logic                ex_rm4,
    input  logic                dtlb_wen,
    input  logic [19:0]         dtlb_vpn,
    input  logic [7:0]          dtlb_ppn,
    stage_tl_if.master          mem,
    output logic                stall,
    output logic [THREAD_W-1:0] tl_thread,
    output logic                tl_isvalid,
    output logic                tl_itlb_miss,
    output logic                tl_dtlb_miss,
    output logic [REG_W-1:0]    tl_dst,
    output logic [31:0]         tl_pc,
    output logic [31:0]         tl_r2,
    output logic [31:0]         tl_data,
    output logic                tl_isequal,
    output logic [31:0]         tl_mul,
    output logic                tl_flag_mul,
    output logic                tl_flag_reg,
    output logic                tl_flag_jump,
    output logic                tl_flag_branch,
    output logic                tl_flag_iret,
    output logic [TLBW_W-1:0]   tl_flag_tlbwrite,
    output logic                tl_flag_load,
    output logic                tl_flag_store
);
    localparam int unsigned VIC_W = (DTLB_ENTRIES > 1) ? $clog2(DTLB_ENTRIES) : 1;

    typedef struct packed {
        logic [THREAD_W-1:0] thread;
        logic                isvalid;
        logic                itlb_miss;
        logic                dtlb_miss;
        logic [REG_W-1:0]    dst;
        logic [31:0]         pc;
        logic [31:0]         r2;
        logic [31:0]         data;
        logic                isequal;
        logic [31:0]         mul;
        logic                flag_mul;
        logic                flag_reg;
        logic                flag_jump;
        logic                flag_branch;
        logic                flag_iret;
        logic [TLBW_W-1:0]   flag_tlbwrite;
        logic                flag_load;
        logic                flag_store;
    } bundle_t;

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    state_t             state_q, state_d;
    bundle_t            tl_q, tl_d, held_q, held_d;
    logic               stall_q, stall_d;
    logic               req_q, req_d, we_q, we_d;
    logic [19:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               valid_q [DTLB_ENTRIES];
    logic               valid_d [DTLB_ENTRIES];
    logic [19:0]        vpn_q   [DTLB_ENTRIES];
    logic [19:0]        vpn_d   [DTLB_ENTRIES];
    logic [7:0]         ppn_q   [DTLB_ENTRIES];
    logic [7:0]         ppn_d   [DTLB_ENTRIES];
    logic [VIC_W-1:0]   victim_q, victim_d;

    bundle_t            ex_b, bubble_b;
    logic               lk_hit, fill_hit, is_mem;
    logic [7:0]         lk_ppn;
    logic [VIC_W-1:0]   fill_idx;
    logic [19:0]        paddr;

    // Incoming EX bundle in output layout; tl_data defaults to the ALU result.
    always_comb begin
        ex_b = '{thread: ex_thread, isvalid: ex_isvalid, itlb_miss: ex_itlb_miss, dtlb_miss: 1'b0,
                 dst: ex_dst, pc: ex_pc, r2: ex_r2, data: ex_alu, isequal: ex_isequal, mul: ex_mul,
                 flag_mul: ex_flag_mul, flag_reg: ex_flag_reg, flag_jump: ex_flag_jump,
                 flag_branch: ex_flag_branch, flag_iret: ex_flag_iret,
                 flag_tlbwrite: ex_flag_tlbwrite, flag_load: ex_flag_load, flag_store: ex_flag_store};
        bubble_b    = '0;
        bubble_b.pc = BUBBLE_PC;
    end

    // Associative searches on current contents; lowest matching index wins.
    always_comb begin
        lk_hit   = 1'b0;
        lk_ppn   = 8'h00;
        fill_hit = 1'b0;
        fill_idx = '0;
        for (int i = 0; i < int'(DTLB_ENTRIES); i++) begin
            if (!lk_hit && valid_q[i] && (vpn_q[i] == ex_alu[31:12])) begin
                lk_hit = 1'b1;
                lk_ppn = ppn_q[i];
            end
            if (!fill_hit && valid_q[i] && (vpn_q[i] == dtlb_vpn)) begin
                fill_hit = 1'b1;
                fill_idx = VIC_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tl_d     = bubble_b;
        held_d   = held_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        valid_d  = valid_q;
        vpn_d    = vpn_q;
        ppn_d    = ppn_q;
        victim_d = victim_q;
        is_mem   = (ex_flag_load || ex_flag_store) && ex_isvalid && !ex_itlb_miss;
        paddr    = ex_rm4 ? ex_alu[19:0] : {lk_ppn, ex_alu[11:0]};

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        tl_d = ex_b;
                    end else if (ex_rm4 || lk_hit) begin
                        held_d  = ex_b;
                        req_d   = 1'b1;
                        we_d    = ex_flag_store;
                        addr_d  = paddr;
                        wdata_d = ex_r2;
                        state_d = MEM_WAIT;
                    end else begin
                        tl_d           = ex_b;
                        tl_d.isvalid   = 1'b0;
                        tl_d.dtlb_miss = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem.ack) begin
                    tl_d = held_q;
                    if (held_q.flag_load) tl_d.data = mem.rdata;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Refill: update an existing mapping in place, otherwise replace round-robin.
        if (dtlb_wen) begin
            if (fill_hit) begin
                ppn_d[fill_idx] = dtlb_ppn;
            end else begin
                valid_d[victim_q] = 1'b1;
                vpn_d[victim_q]   = dtlb_vpn;
                ppn_d[victim_q]   = dtlb_ppn;
                victim_d          = victim_q + VIC_W'(1);
            end
        end
        stall_d = (state_d == MEM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tl_q     <= bubble_b;
            held_q   <= '0;
            stall_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            valid_q  <= '{default: 1'b0};
            vpn_q    <= '{default: '0};
            ppn_q    <= '{default: '0};
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            tl_q     <= tl_d;
            held_q   <= held_d;
            stall_q  <= stall_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            valid_q  <= valid_d;
            vpn_q    <= vpn_d;
            ppn_q    <= ppn_d;
            victim_q <= victim_d;
        end
    end

    assign stall            = stall_q;
    assign mem.req          = req_q;
    assign mem.we           = we_q;
    assign mem.addr         = addr_q;
    assign mem.wdata        = wdata_q;
    assign tl_thread        = tl_q.thread;
    assign tl_isvalid       = tl_q.isvalid;
    assign tl_itlb_miss     = tl_q.itlb_miss;
    assign tl_dtlb_miss     = tl_q.dtlb_miss;
    assign tl_dst           = tl_q.dst;
    assign tl_pc            = tl_q.pc;
    assign tl_r2            = tl_q.r2;
    assign tl_data          = tl_q.data;
    assign tl_isequal       = tl_q.isequal;
    assign tl_mul           = tl_q.mul;
    assign tl_flag_mul      = tl_q.flag_mul;
    assign tl_flag_reg      = tl_q.flag_reg;
    assign tl_flag_jump     = tl_q.flag_jump;
    assign tl_flag_branch   = tl_q.flag_branch;
    assign tl_flag_iret     = tl_q.flag_iret;
    assign tl_flag_tlbwrite = tl_q.flag_tlbwrite;
    assign tl_flag_load     = tl_q.flag_load;
    assign tl_flag_store    = tl_q.flag_store;
endmodule

// File: tb/tb_stage_tl.sv
// Self-checking bench for stage_tl: directed scenarios plus randomized traffic against a FIFO-replacement TLB model.
module tb_stage_tl;
    localparam int unsigned N   = 4;
    localparam logic [31:0] BPC = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [1:0]  thread;
        logic        isvalid;
        logic        itlb_miss;
        logic        dtlb_miss;
        logic [4:0]  dst;
        logic [31:0] pc;
        logic [31:0] r2;
        logic [31:0] data;
        logic        isequal;
        logic [31:0] mul;
        logic        flag_mul;
        logic        flag_reg;
        logic        flag_jump;
        logic        flag_branch;
        logic        flag_iret;
        logic [1:0]  flag_tlbwrite;
        logic        flag_load;
        logic        flag_store;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_isvalid, ex_itlb_miss, ex_isequal, ex_rm4;
    logic [1:0]  ex_thread, ex_flag_tlbwrite;
    logic [4:0]  ex_dst;
    logic [31:0] ex_pc, ex_r2, ex_alu, ex_mul;
    logic        ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret;
    logic        ex_flag_load, ex_flag_store;
    logic        dtlb_wen;
    logic [19:0] dtlb_vpn;
    logic [7:0]  dtlb_ppn;
    logic        stall;
    logic [1:0]  tl_thread, tl_flag_tlbwrite;
    logic        tl_isvalid, tl_itlb_miss, tl_dtlb_miss, tl_isequal;
    logic [4:0]  tl_dst;
    logic [31:0] tl_pc, tl_r2, tl_data, tl_mul;
    logic        tl_flag_mul, tl_flag_reg, tl_flag_jump, tl_flag_branch, tl_flag_iret;
    logic        tl_flag_load, tl_flag_store;

    int total  = 0;
    int passed = 0;

    stage_tl_if mem_if ();

    stage_tl #(.DTLB_ENTRIES(N), .BUBBLE_PC(BPC)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_thread(ex_thread), .ex_isvalid(ex_isvalid), .ex_itlb_miss(ex_itlb_miss),
        .ex_dst(ex_dst), .ex_pc(ex_pc), .ex_r2(ex_r2), .ex_alu(ex_alu), .ex_isequal(ex_isequal),
        .ex_mul(ex_mul), .ex_flag_mul(ex_flag_mul), .ex_flag_reg(ex_flag_reg), .ex_flag_jump(ex_flag_jump),
        .ex_flag_branch(ex_flag_branch), .ex_flag_iret(ex_flag_iret), .ex_flag_tlbwrite(ex_flag_tlbwrite),
        .ex_flag_load(ex_flag_load), .ex_flag_store(ex_flag_store), .ex_rm4(ex_rm4),
        .dtlb_wen(dtlb_wen), .dtlb_vpn(dtlb_vpn), .dtlb_ppn(dtlb_ppn),
        .mem(mem_if), .stall(stall),
        .tl_thread(tl_thread), .tl_isvalid(tl_isvalid), .tl_itlb_miss(tl_itlb_miss),
        .tl_dtlb_miss(tl_dtlb_miss), .tl_dst(tl_dst), .tl_pc(tl_pc), .tl_r2(tl_r2), .tl_data(tl_data),
        .tl_isequal(tl_isequal), .tl_mul(tl_mul), .tl_flag_mul(tl_flag_mul), .tl_flag_reg(tl_flag_reg),
        .tl_flag_jump(tl_flag_jump), .tl_flag_branch(tl_flag_branch), .tl_flag_iret(tl_flag_iret),
        .tl_flag_tlbwrite(tl_flag_tlbwrite), .tl_flag_load(tl_flag_load), .tl_flag_store(tl_flag_store)
    );

    always #5 clk = ~clk;

    exp_t obs;
    assign obs = {tl_thread, tl_isvalid, tl_itlb_miss, tl_dtlb_miss, tl_dst, tl_pc, tl_r2, tl_data,
                  tl_isequal, tl_mul, tl_flag_mul, tl_flag_reg, tl_flag_jump, tl_flag_branch,
                  tl_flag_iret, tl_flag_tlbwrite, tl_flag_load, tl_flag_store};

    exp_t bub;
    initial begin
        bub    = '0;
        bub.pc = BPC;
    end

    // Reference dTLB: oldest-installed mapping is the one replaced; refills only change the ppn.
    logic [19:0] m_order [$];
    logic [7:0]  m_map [logic [19:0]];

    function automatic void m_reset();
        m_order.delete();
        m_map.delete();
    endfunction

    function automatic void m_fill(input logic [19:0] vpn, input logic [7:0] ppn);
        if (!m_map.exists(vpn)) begin
            if (m_order.size() == N) m_map.delete(m_order.pop_front());
            m_order.push_back(vpn);
        end
        m_map[vpn] = ppn;
    endfunction

    function automatic bit m_lookup(input logic [31:0] va, output logic [7:0] ppn);
        ppn = 8'h00;
        if (!m_map.exists(va[31:12])) return 1'b0;
        ppn = m_map[va[31:12]];
        return 1'b1;
    endfunction

    function automatic exp_t from_ex();
        exp_t e;
        e = '{thread: ex_thread, isvalid: ex_isvalid, itlb_miss: ex_itlb_miss, dtlb_miss: 1'b0,
              dst: ex_dst, pc: ex_pc, r2: ex_r2, data: ex_alu, isequal: ex_isequal, mul: ex_mul,
              flag_mul: ex_flag_mul, flag_reg: ex_flag_reg, flag_jump: ex_flag_jump,
              flag_branch: ex_flag_branch, flag_iret: ex_flag_iret, flag_tlbwrite: ex_flag_tlbwrite,
              flag_load: ex_flag_load, flag_store: ex_flag_store};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_thread = 0; ex_isvalid = 0; ex_itlb_miss = 0; ex_dst = 0; ex_pc = 0;
        ex_r2 = 0; ex_alu = 0; ex_isequal = 0; ex_mul = 0; ex_flag_mul = 0; ex_flag_reg = 0;
        ex_flag_jump = 0; ex_flag_branch = 0; ex_flag_iret = 0; ex_flag_tlbwrite = 0;
        ex_flag_load = 0; ex_flag_store = 0; ex_rm4 = 0;
    endtask

    task automatic set_mem(input logic [31:0] va, input logic ld, input logic st, input logic rm4,
                           input logic [31:0] r2);
        clear_ex();
        ex_valid = 1; ex_isvalid = 1; ex_pc = 32'h0000_0200; ex_dst = 5'd3; ex_thread = 2'd1;
        ex_alu = va; ex_flag_load = ld; ex_flag_store = st; ex_rm4 = rm4; ex_r2 = r2;
    endtask

    task automatic do_reset();
        rst = 1; clear_ex(); dtlb_wen = 0; dtlb_vpn = 0; dtlb_ppn = 0;
        mem_if.ack = 0; mem_if.rdata = 0;
        step(); step();
        rst = 0;
        m_reset();
    endtask

    task automatic do_fill(input logic [19:0] vpn, input logic [7:0] ppn);
        dtlb_wen = 1; dtlb_vpn = vpn; dtlb_ppn = ppn;
        step();
        dtlb_wen = 0;
        m_fill(vpn, ppn);
    endtask

    // Presents the driven EX bundle, answers any access after k wait cycles, returns what was seen.
    task automatic issue(input int k, input logic [31:0] rd, output logic req, output logic we,
                         output logic [19:0] addr, output logic [31:0] wdata, output int stall_cyc,
                         output bit stable, output exp_t res);
        step();
        dtlb_wen = 0;
        req = mem_if.req; we = mem_if.we; addr = mem_if.addr; wdata = mem_if.wdata;
        stall_cyc = 0; stable = 1;
        if (stall) begin
            ex_alu = $urandom;
            for (int c = 1; c <= k; c++) begin
                if (stall) stall_cyc++;
                if (mem_if.req !== 1'b1 || mem_if.addr !== addr || mem_if.we !== we || mem_if.wdata !== wdata)
                    stable = 0;
                if (c == k) begin mem_if.ack = 1; mem_if.rdata = rd; ex_valid = 0; end
                step();
            end
            mem_if.ack = 0;
        end else begin
            ex_valid = 0;
        end
        res = obs;
    endtask

    logic        r_req, r_we;
    logic [19:0] r_addr;
    logic [31:0] r_wdata;
    int          r_stall;
    bit          r_stable;
    exp_t        r_res, exp_b;

    task automatic test_reset();
        do_reset();
        total++; if (tl_isvalid !== 1'b0) $display("FAIL reset_isvalid got %h exp 0", tl_isvalid); else passed++;
        total++; if (tl_pc !== BPC) $display("FAIL reset_pc got %h exp %h", tl_pc, BPC); else passed++;
        total++; if (mem_if.req !== 1'b0 || mem_if.we !== 1'b0) $display("FAIL reset_req got %b%b exp 00", mem_if.req, mem_if.we); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (obs !== bub || mem_if.req !== 1'b0 || stall !== 1'b0)
                $display("FAIL idle_bubble got %h req %b stall %b exp %h", obs, mem_if.req, stall, bub); else passed++;
        end
    endtask

    task automatic test_alu();
        clear_ex();
        ex_valid = 1; ex_isvalid = 1; ex_pc = 32'h100; ex_alu = 32'h55; ex_flag_reg = 1;
        exp_b = from_ex();
        issue(1, 0, r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
        total++; if (r_res !== exp_b) $display("FAIL alu_bundle got %h exp %h", r_res, exp_b); else passed++;
        total++; if (tl_pc !== 32'h100 || tl_data !== 32'h55 || tl_flag_reg !== 1'b1 || tl_isvalid !== 1'b1)
            $display("FAIL alu_fields got pc %h data %h exp pc 100 data 55", tl_pc, tl_data); else passed++;
        total++; if (r_req !== 1'b0 || r_stall !== 0) $display("FAIL alu_nomem got req %b stall %0d exp 0 0", r_req, r_stall); else passed++;
        step();
        total++; if (obs !== bub) $display("FAIL alu_hold got %h exp %h", obs, bub); else passed++;
    endtask

    task automatic test_load_miss();
        set_mem(32'h0000_3A10, 1, 0, 0, 32'h0);
        issue(1, 0, r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
        total++; if (tl_dtlb_miss !== 1'b1 || tl_isvalid !== 1'b0 || tl_data !== 32'h3A10)
            $display("FAIL miss_fields got miss %b valid %b data %h exp 1 0 3a10", tl_dtlb_miss, tl_isvalid, tl_data); else passed++;
        total++; if (r_req !== 1'b0 || mem_if.req !== 1'b0) $display("FAIL miss_noreq got %b exp 0", r_req); else passed++;
    endtask

    task automatic test_load_hit();
        do_fill(20'h00003, 8'h7F);
        set_mem(32'h0000_3A10, 1, 0, 0, 32'h0);
        exp_b = from_ex(); exp_b.data = 32'hDEAD;
        issue(3, 32'hDEAD, r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
        total++; if (r_addr !== 20'h7FA10 || r_req !== 1'b1 || r_we !== 1'b0)
            $display("FAIL hit_addr got %h req %b we %b exp 7fa10 1 0", r_addr, r_req, r_we); else passed++;
        total++; if (r_stall !== 3 || !r_stable) $display("FAIL hit_stall got %0d stable %0d exp 3 1", r_stall, r_stable); else passed++;
        total++; if (r_res !== exp_b) $display("FAIL hit_bundle got %h exp %h", r_res, exp_b); else passed++;
        total++; if (mem_if.req !== 1'b0 || stall !== 1'b0) $display("FAIL hit_release got req %b stall %b exp 0 0", mem_if.req, stall); else passed++;
    endtask

    task automatic test_store_rm4();
        set_mem(32'h0000_1234, 0, 1, 1, 32'hBEEF);
        exp_b = from_ex();
        issue(1, 32'h1111_2222, r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
        total++; if (r_we !== 1'b1 || r_addr !== 20'h01234 || r_wdata !== 32'hBEEF)
            $display("FAIL st_port got we %b addr %h wd %h exp 1 01234 beef", r_we, r_addr, r_wdata); else passed++;
        total++; if (r_res !== exp_b || r_stall !== 1) $display("FAIL st_bundle got %h stall %0d exp %h 1", r_res, r_stall, exp_b); else passed++;
    endtask

    task automatic test_eviction();
        logic [19:0] vpns  [8] = '{20'h10, 20'h11, 20'h12, 20'h13, 20'h14, 20'h11, 20'h11, 20'h12};
        bit          hits  [8] = '{0, 1, 1, 1, 1, 1, 0, 1};
        logic [7:0]  p;
        bit          mh;
        do_reset();
        for (int i = 0; i < 5; i++) do_fill(20'h10 + 20'(i), 8'hA0 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            if (i == 5) do_fill(20'h11, 8'hB1);
            if (i == 6) do_fill(20'h15, 8'hC5);
            set_mem({vpns[i], 12'h5C8}, 1, 0, 0, 32'h0);
            mh = m_lookup(ex_alu, p);
            issue(1, 32'hCAFE_0000 + 32'(i), r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
            total++; if (r_req !== hits[i] || mh !== hits[i])
                $display("FAIL evict_hit[%0d] got %b model %b exp %b", i, r_req, mh, hits[i]); else passed++;
            if (hits[i]) begin
                total++; if (r_addr !== {p, 12'h5C8} || r_res.data !== 32'hCAFE_0000 + 32'(i))
                    $display("FAIL evict_addr[%0d] got %h data %h exp %h", i, r_addr, r_res.data, {p, 12'h5C8}); else passed++;
            end else begin
                total++; if (r_res.dtlb_miss !== 1'b1 || r_res.isvalid !== 1'b0)
                    $display("FAIL evict_miss[%0d] got miss %b valid %b exp 1 0", i, r_res.dtlb_miss, r_res.isvalid); else passed++;
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  p;
        logic [31:0] rd;
        bit          exp_mem;
        logic [19:0] exp_addr;
        int          k;
        for (int n = 0; n < 200; n++) begin
            clear_ex();
            ex_valid = ($urandom % 5) != 0; ex_thread = 2'($urandom); ex_isvalid = ($urandom % 10) != 0;
            ex_itlb_miss = ($urandom % 10) == 0; ex_dst = 5'($urandom); ex_pc = $urandom & 32'h7FFF_FFFC;
            ex_r2 = $urandom; ex_alu = {20'($urandom % 8), 12'($urandom)}; ex_isequal = 1'($urandom);
            ex_mul = $urandom; ex_flag_mul = 1'($urandom); ex_flag_reg = 1'($urandom);
            ex_flag_jump = 1'($urandom); ex_flag_branch = 1'($urandom); ex_flag_iret = 1'($urandom);
            ex_flag_tlbwrite = 2'($urandom); ex_rm4 = ($urandom % 8) == 0;
            case ($urandom % 5)
                2, 3:    ex_flag_load = 1;
                4:       ex_flag_store = 1;
                default: ;
            endcase
            dtlb_wen = ($urandom % 3) == 0; dtlb_vpn = 20'($urandom % 8); dtlb_ppn = 8'($urandom);
            k = 1 + int'($urandom % 4); rd = $urandom;
            exp_b = bub; exp_mem = 0; exp_addr = '0;
            if (ex_valid) begin
                exp_b = from_ex();
                if ((ex_flag_load || ex_flag_store) && ex_isvalid && !ex_itlb_miss) begin
                    if (ex_rm4) begin exp_mem = 1; exp_addr = ex_alu[19:0]; end
                    else if (m_lookup(ex_alu, p)) begin exp_mem = 1; exp_addr = {p, ex_alu[11:0]}; end
                    else begin exp_b.isvalid = 0; exp_b.dtlb_miss = 1; end
                    if (exp_mem && ex_flag_load) exp_b.data = rd;
                end
            end
            if (dtlb_wen) m_fill(dtlb_vpn, dtlb_ppn);
            issue(k, rd, r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
            total++; if (r_res !== exp_b) $display("FAIL rnd_bundle[%0d] got %h exp %h", n, r_res, exp_b); else passed++;
            total++; if (r_req !== exp_mem) $display("FAIL rnd_req[%0d] got %b exp %b", n, r_req, exp_mem); else passed++;
            if (exp_mem) begin
                total++; if (r_addr !== exp_addr || r_we !== exp_b.flag_store || r_wdata !== exp_b.r2 || r_stall !== k || !r_stable)
                    $display("FAIL rnd_access[%0d] got %h we %b stall %0d exp %h we %b stall %0d", n, r_addr, r_we, r_stall, exp_addr, exp_b.flag_store, k); else passed++;
            end
            if ($urandom % 2) begin
                step();
                total++; if (obs !== bub) $display("FAIL rnd_gap[%0d] got %h exp %h", n, obs, bub); else passed++;
            end
        end
    endtask

    task automatic test_reset_in_wait();
        do_fill(20'h00002, 8'h22);
        set_mem(32'h0000_2ABC, 1, 0, 0, 32'h0);
        step();
        total++; if (stall !== 1'b1 || mem_if.req !== 1'b1) $display("FAIL rw_enter got stall %b req %b exp 1 1", stall, mem_if.req); else passed++;
        rst = 1; ex_valid = 0;
        step();
        rst = 0; m_reset();
        total++; if (mem_if.req !== 1'b0 || stall !== 1'b0 || obs !== bub)
            $display("FAIL rw_reset got req %b stall %b tl %h exp 0 0 %h", mem_if.req, stall, obs, bub); else passed++;
        set_mem(32'h0000_2ABC, 1, 0, 0, 32'h0);
        issue(1, 0, r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
        total++; if (r_req !== 1'b0 || r_res.dtlb_miss !== 1'b1) $display("FAIL rw_tlbclr got req %b miss %b exp 0 1", r_req, r_res.dtlb_miss); else passed++;
        clear_ex(); ex_valid = 1; ex_isvalid = 1; ex_pc = 32'h300; ex_alu = 32'h77;
        exp_b = from_ex();
        issue(1, 0, r_req, r_we, r_addr, r_wdata, r_stall, r_stable, r_res);
        total++; if (r_res !== exp_b) $display("FAIL rw_idle got %h exp %h", r_res, exp_b); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_miss();
        test_load_hit();
        test_store_rm4();
        test_eviction();
        test_random();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stage_tl.md
Name: stage_tl

Overview:
- Translation/memory stage between EX and WB; produces the complete tl_* bundle consumed by stage_wb.
- Holds a small fully-associative data TLB, refilled from WB's dtlb write port. Translates load/store addresses and performs the memory access through a req/ack port.
- Stalls upstream while an access is outstanding.

Parameters:
DTLB_ENTRIES, 4, number of fully-associative dTLB entries (power of two, >=2)
BUBBLE_PC, 32'hFFFF_FFFF, tl_pc driven on bubbles; never equals a legal waiting PC

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  EX bundle present this cycle
ex_thread  in  threadid_t  thread id
ex_isvalid  in  1  instruction executed without error
ex_itlb_miss  in  1  fetch TLB miss
ex_dst  in  regid_t  destination register
ex_pc  in  32  instruction PC
ex_r2  in  32  second operand / store data / TLBWRITE ppn
ex_alu  in  32  ALU result / effective address
ex_isequal  in  1  branch compare result
ex_mul  in  32  multiplier result
ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret  in  1 each  control flags
ex_flag_tlbwrite  in  tlbwrite_t  TLBWRITE target
ex_flag_load, ex_flag_store  in  1 each  memory operation
ex_rm4  in  1  thread in supervisor mode (translation bypassed)
dtlb_wen  in  1  dTLB fill from WB
dtlb_vpn  in  20  fill VPN
dtlb_ppn  in  8  fill PPN
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  20  physical address {ppn, va[11:0]}
mem_wdata  out  32  store data
mem_ack  in  1  request completed
mem_rdata  in  32  load data, valid with mem_ack
stall  out  1  upstream must hold its bundle
tl_thread … tl_flag_tlbwrite  out  match stage_wb tl_* inputs  registered bundle to WB

Behaviour:
- Reset: all tl_* = 0 except tl_pc = BUBBLE_PC, tl_isvalid = 0. All dTLB entries invalid; victim pointer = 0; state IDLE; mem_req = mem_we = 0; stall = 0. Reset during MEM_WAIT abandons the access and drops mem_req the following cycle.
- States: IDLE, MEM_WAIT. stall = (state == MEM_WAIT), registered-state only.
- IDLE, ex_valid = 0: next-cycle bubble with tl_isvalid = 0, tl_pc = BUBBLE_PC, no memory or TLB side effects.
- IDLE, non-memory instruction, or ex_isvalid = 0, or ex_itlb_miss = 1: the bundle is copied to tl_* next cycle with tl_data = ex_alu and tl_dtlb_miss = 0. Latency 1 cycle; no memory access.
- IDLE, load/store: lookup on ex_alu[31:12] against valid entries, combinationally on current contents.
  - ex_rm4 = 1: forced hit, paddr = ex_alu[19:0].
  - Miss: next cycle tl_* copied, tl_isvalid = 0, tl_dtlb_miss = 1, tl_data = ex_alu (faulting VA); no access.
  - Hit: latch bundle, mem_addr = {ppn, ex_alu[11:0]}, mem_we = ex_flag_store, mem_wdata = ex_r2. Go to MEM_WAIT; the tl_* output is a bubble meanwhile.
- MEM_WAIT: mem_req = 1 with addr/we/wdata held stable until mem_ack. In the mem_ack cycle: mem_req drops next edge, tl_* emitted next cycle with tl_isvalid = latched isvalid, tl_data = mem_rdata (load) or latched ex_alu (store). Return to IDLE. Latency = k+1 cycles for ack after k cycles (k >= 1). ex_* ignored while in MEM_WAIT; the held bundle is accepted on the first IDLE cycle.
- Every emitted bundle is held exactly one cycle; a bubble follows unless a new bundle is accepted.
- Fill: on dtlb_wen, if dtlb_vpn matches a valid entry, overwrite its ppn; else write entry[victim] valid and victim <= (victim+1) mod DTLB_ENTRIES. Write takes effect at the edge; a same-cycle lookup sees old contents.
- A single match is guaranteed by fill rule; priority to lowest index if violated.

Test Plan:
- Reset, then ex_valid=0 for 3 cycles -> tl_isvalid=0, tl_pc=FFFF_FFFF, mem_req=0, stall=0.
- ALU op pc=0x100, alu=0x55, flag_reg=1 -> next cycle tl_pc=0x100, tl_data=0x55, tl_flag_reg=1, tl_isvalid=1.
- Load va=0x0000_3A10, empty TLB, rm4=0 -> tl_dtlb_miss=1, tl_isvalid=0, tl_data=0x3A10, mem_req never asserted.
- Fill vpn=0x00003 ppn=0x7F, then load va=0x3A10, ack after 3 cycles with rdata=0xDEAD -> mem_addr=0x7FA10, stall high 3 cycles, tl_data=0xDEAD.
- Store with rm4=1, va=0x1234, r2=0xBEEF -> mem_we=1, mem_addr=0x01234, mem_wdata=0xBEEF, no TLB use.
- Five distinct fills with DTLB_ENTRIES=4 -> first VPN evicted (misses), other four hit; refill of existing VPN does not advance victim. Assert rst in MEM_WAIT -> mem_req=0 next cycle, state IDLE.
